// File: rtl/mod_param_scheduler_if.sv
// Bus between the CPU shadow-register side and the modulation parameter scheduler.
// The master drives shadow values and step pulses; the scheduler drives the generator values.
interface mod_param_scheduler_if #(
    parameter int unsigned DW = 32
);
    logic [DW-1:0] cpu_freq_cnt;
    logic [DW-1:0] cpu_amp_h;
    logic [DW-1:0] cpu_amp_l;
    logic [DW-1:0] cpu_slew;
    logic          cpu_commit;
    logic          step_trig;
    logic [DW-1:0] freq_cnt;
    logic [DW-1:0] amp_h;
    logic [DW-1:0] amp_l;
    logic          busy;
    logic          apply;
    logic          done;

    modport master (
        output cpu_freq_cnt, cpu_amp_h, cpu_amp_l, cpu_slew, cpu_commit, step_trig,
        input  freq_cnt, amp_h, amp_l, busy, apply, done
    );

    modport slave (
        input  cpu_freq_cnt, cpu_amp_h, cpu_amp_l, cpu_slew, cpu_commit, step_trig,
        output freq_cnt, amp_h, amp_l, busy, apply, done
    );
endinterface

// File: rtl/mod_param_scheduler.sv
// Commits CPU-written modulation parameters to the square-wave generator only on step
// boundaries, slewing the signed amplitudes toward their targets in bounded steps.
module mod_param_scheduler #(
    parameter int unsigned DW           = 32,
    parameter int unsigned RST_FREQ_CNT = 100
) (
    input logic                clk,
    input logic                rst_n,
    mod_param_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RAMP = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] tgt_freq;
    logic [DW-1:0] tgt_h;
    logic [DW-1:0] tgt_l;
    logic [DW-1:0] slew;
    logic [DW-1:0] freq_cnt;
    logic [DW-1:0] amp_h;
    logic [DW-1:0] amp_l;
    logic          busy;
    logic          apply;
    logic          done;

    logic [DW-1:0] nxt_h;
    logic [DW-1:0] nxt_l;
    logic          amps_reached;
    logic          amps_change;

    // One slew step from cur toward tgt; the difference is taken one bit wider so
    // opposite-sign extremes cannot wrap, and the step is clamped to land on tgt.
    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] tgt,
                                                  input logic [DW-1:0] lim);
        logic signed [DW:0] diff;
        logic        [DW:0] mag;
        diff = $signed({tgt[DW-1], tgt}) - $signed({cur[DW-1], cur});
        mag  = diff[DW] ? (DW+1)'(-diff) : (DW+1)'(diff);
        if (lim == '0 || mag <= {1'b0, lim}) begin
            return tgt;
        end else if (diff[DW]) begin
            return cur - lim;
        end else begin
            return cur + lim;
        end
    endfunction

    always_comb begin
        nxt_h        = step_toward(amp_h, tgt_h, slew);
        nxt_l        = step_toward(amp_l, tgt_l, slew);
        amps_reached = (nxt_h == tgt_h) && (nxt_l == tgt_l);
        amps_change  = (nxt_h != amp_h) || (nxt_l != amp_l);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tgt_freq <= DW'(RST_FREQ_CNT);
            tgt_h    <= '0;
            tgt_l    <= '0;
            slew     <= '0;
            freq_cnt <= DW'(RST_FREQ_CNT);
            amp_h    <= '0;
            amp_l    <= '0;
            busy     <= 1'b0;
            apply    <= 1'b0;
            done     <= 1'b0;
        end else begin
            apply <= 1'b0;
            done  <= 1'b0;
            // A commit always wins: it supersedes any pending target and defers the apply.
            if (bus.cpu_commit) begin
                tgt_freq <= bus.cpu_freq_cnt;
                tgt_h    <= bus.cpu_amp_h;
                tgt_l    <= bus.cpu_amp_l;
                slew     <= bus.cpu_slew;
                busy     <= 1'b1;
                state    <= PEND;
            end else begin
                case (state)
                    IDLE: ;
                    PEND: begin
                        if (bus.step_trig) begin
                            freq_cnt <= tgt_freq;
                            amp_h    <= nxt_h;
                            amp_l    <= nxt_l;
                            apply    <= amps_change || (freq_cnt != tgt_freq);
                            if (amps_reached) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= RAMP;
                            end
                        end
                    end
                    RAMP: begin
                        if (bus.step_trig) begin
                            amp_h <= nxt_h;
                            amp_l <= nxt_l;
                            apply <= amps_change;
                            if (amps_reached) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.freq_cnt = freq_cnt;
    assign bus.amp_h    = amp_h;
    assign bus.amp_l    = amp_l;
    assign bus.busy     = busy;
    assign bus.apply    = apply;
    assign bus.done     = done;

endmodule

// File: tb/tb_mod_param_scheduler.sv
// Directed bench for mod_param_scheduler: jump, slew ramps, extremes, re-commit and reset.
module tb_mod_param_scheduler;

    localparam int unsigned DW = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mod_param_scheduler_if #(.DW(DW)) bus ();

    mod_param_scheduler #(.DW(DW), .RST_FREQ_CNT(100)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic commit(input logic [31:0] f, input logic [31:0] h, input logic [31:0] l,
                          input logic [31:0] s, input logic with_trig);
        @(negedge clk);
        bus.cpu_freq_cnt = f;
        bus.cpu_amp_h    = h;
        bus.cpu_amp_l    = l;
        bus.cpu_slew     = s;
        bus.cpu_commit   = 1'b1;
        bus.step_trig    = with_trig;
        @(negedge clk);
        bus.cpu_commit   = 1'b0;
        bus.step_trig    = 1'b0;
    endtask

    task automatic trig();
        @(negedge clk);
        bus.step_trig = 1'b1;
        @(negedge clk);
        bus.step_trig = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus.freq_cnt !== 32'd100) begin errors++; $display("FAIL reset_freq got %0d want 100", bus.freq_cnt); end
        if (bus.amp_h !== 32'd0) begin errors++; $display("FAIL reset_amp_h got %h want 0", bus.amp_h); end
        if (bus.amp_l !== 32'd0) begin errors++; $display("FAIL reset_amp_l got %h want 0", bus.amp_l); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.apply !== 1'b0) begin errors++; $display("FAIL reset_apply got %b want 0", bus.apply); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    endtask

    task automatic test_jump();
        commit(32'd250, 32'd1000, -32'sd1000, 32'd0, 1'b0);
        checks += 3;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL jump_busy_commit got %b want 1", bus.busy); end
        if (bus.freq_cnt !== 32'd100) begin errors++; $display("FAIL jump_freq_hold got %0d want 100", bus.freq_cnt); end
        if (bus.amp_h !== 32'd0) begin errors++; $display("FAIL jump_h_hold got %h want 0", bus.amp_h); end
        @(negedge clk);
        checks++;
        if (bus.amp_l !== 32'd0) begin errors++; $display("FAIL jump_l_hold got %h want 0", bus.amp_l); end
        trig();
        checks += 6;
        if (bus.freq_cnt !== 32'd250) begin errors++; $display("FAIL jump_freq got %0d want 250", bus.freq_cnt); end
        if (bus.amp_h !== 32'd1000) begin errors++; $display("FAIL jump_h got %h want 3e8", bus.amp_h); end
        if (bus.amp_l !== 32'hFFFFFC18) begin errors++; $display("FAIL jump_l got %h want fffffc18", bus.amp_l); end
        if (bus.apply !== 1'b1) begin errors++; $display("FAIL jump_apply got %b want 1", bus.apply); end
        if (bus.done !== 1'b1) begin errors++; $display("FAIL jump_done got %b want 1", bus.done); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL jump_busy got %b want 0", bus.busy); end
        @(negedge clk);
        checks += 2;
        if (bus.apply !== 1'b0) begin errors++; $display("FAIL jump_apply_pulse got %b want 0", bus.apply); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL jump_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_slew();
        logic [31:0] exp_h [3];
        logic        exp_d [3];
        exp_h = '{32'd400, 32'd800, 32'd1000};
        exp_d = '{1'b0, 1'b0, 1'b1};
        do_reset();
        commit(32'd500, 32'd1000, -32'sd300, 32'd400, 1'b0);
        for (int i = 0; i < 3; i++) begin
            trig();
            checks += 6;
            if (bus.amp_h !== exp_h[i]) begin errors++; $display("FAIL slew_h[%0d] got %0d want %0d", i, bus.amp_h, exp_h[i]); end
            if (bus.amp_l !== 32'hFFFFFED4) begin errors++; $display("FAIL slew_l[%0d] got %h want fffffed4", i, bus.amp_l); end
            if (bus.freq_cnt !== 32'd500) begin errors++; $display("FAIL slew_freq[%0d] got %0d want 500", i, bus.freq_cnt); end
            if (bus.apply !== 1'b1) begin errors++; $display("FAIL slew_apply[%0d] got %b want 1", i, bus.apply); end
            if (bus.done !== exp_d[i]) begin errors++; $display("FAIL slew_done[%0d] got %b want %b", i, bus.done, exp_d[i]); end
            if (bus.busy !== !exp_d[i]) begin errors++; $display("FAIL slew_busy[%0d] got %b want %b", i, bus.busy, !exp_d[i]); end
        end
    endtask

    task automatic test_extremes();
        logic [31:0] exp_h [4];
        logic        exp_d [4];
        exp_h = '{32'hC0000000, 32'h00000000, 32'h40000000, 32'h7FFFFFFF};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b1};
        commit(32'd500, 32'h7FFFFFFF, -32'sd300, 32'd0, 1'b0);
        trig();
        checks++;
        if (bus.amp_h !== 32'h7FFFFFFF) begin errors++; $display("FAIL ext_max got %h want 7fffffff", bus.amp_h); end
        commit(32'd500, 32'h80000000, -32'sd300, 32'd0, 1'b0);
        trig();
        checks += 2;
        if (bus.amp_h !== 32'h80000000) begin errors++; $display("FAIL ext_jump_min got %h want 80000000", bus.amp_h); end
        if (bus.done !== 1'b1) begin errors++; $display("FAIL ext_jump_done got %b want 1", bus.done); end
        commit(32'd500, 32'h7FFFFFFF, -32'sd300, 32'h40000000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            trig();
            checks += 3;
            if (bus.amp_h !== exp_h[i]) begin errors++; $display("FAIL ext_ramp_h[%0d] got %h want %h", i, bus.amp_h, exp_h[i]); end
            if (bus.done !== exp_d[i]) begin errors++; $display("FAIL ext_ramp_done[%0d] got %b want %b", i, bus.done, exp_d[i]); end
            if (bus.apply !== 1'b1) begin errors++; $display("FAIL ext_ramp_apply[%0d] got %b want 1", i, bus.apply); end
        end
    endtask

    task automatic test_recommit();
        do_reset();
        commit(32'd500, 32'd1000, -32'sd300, 32'd400, 1'b0);
        trig();
        checks++;
        if (bus.amp_h !== 32'd400) begin errors++; $display("FAIL recommit_first got %0d want 400", bus.amp_h); end
        commit(32'd500, -32'sd200, -32'sd300, 32'd400, 1'b0);
        checks += 2;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL recommit_no_done got %b want 0", bus.done); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL recommit_busy got %b want 1", bus.busy); end
        trig();
        checks += 4;
        if (bus.amp_h !== 32'd0) begin errors++; $display("FAIL recommit_h1 got %h want 0", bus.amp_h); end
        if (bus.apply !== 1'b1) begin errors++; $display("FAIL recommit_apply1 got %b want 1", bus.apply); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL recommit_done1 got %b want 0", bus.done); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL recommit_busy1 got %b want 1", bus.busy); end
        trig();
        checks += 3;
        if (bus.amp_h !== 32'hFFFFFF38) begin errors++; $display("FAIL recommit_h2 got %h want ffffff38", bus.amp_h); end
        if (bus.done !== 1'b1) begin errors++; $display("FAIL recommit_done2 got %b want 1", bus.done); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL recommit_busy2 got %b want 0", bus.busy); end
    endtask

    task automatic test_same_commit();
        commit(32'd500, -32'sd200, -32'sd300, 32'd400, 1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL same_busy got %b want 1", bus.busy); end
        trig();
        checks += 3;
        if (bus.apply !== 1'b0) begin errors++; $display("FAIL same_apply got %b want 0", bus.apply); end
        if (bus.done !== 1'b1) begin errors++; $display("FAIL same_done got %b want 1", bus.done); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL same_busy_end got %b want 0", bus.busy); end
    endtask

    task automatic test_idle_trig();
        trig();
        checks += 3;
        if (bus.apply !== 1'b0) begin errors++; $display("FAIL idle_apply got %b want 0", bus.apply); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", bus.done); end
        if (bus.amp_h !== 32'hFFFFFF38) begin errors++; $display("FAIL idle_h got %h want ffffff38", bus.amp_h); end
    endtask

    task automatic test_commit_with_trig();
        commit(32'd700, 32'd50, -32'sd300, 32'd0, 1'b1);
        checks += 4;
        if (bus.apply !== 1'b0) begin errors++; $display("FAIL cwt_apply got %b want 0", bus.apply); end
        if (bus.amp_h !== 32'hFFFFFF38) begin errors++; $display("FAIL cwt_h_hold got %h want ffffff38", bus.amp_h); end
        if (bus.freq_cnt !== 32'd500) begin errors++; $display("FAIL cwt_freq_hold got %0d want 500", bus.freq_cnt); end
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL cwt_busy got %b want 1", bus.busy); end
        trig();
        checks += 4;
        if (bus.amp_h !== 32'd50) begin errors++; $display("FAIL cwt_h got %0d want 50", bus.amp_h); end
        if (bus.freq_cnt !== 32'd700) begin errors++; $display("FAIL cwt_freq got %0d want 700", bus.freq_cnt); end
        if (bus.apply !== 1'b1) begin errors++; $display("FAIL cwt_apply2 got %b want 1", bus.apply); end
        if (bus.done !== 1'b1) begin errors++; $display("FAIL cwt_done got %b want 1", bus.done); end
    endtask

    task automatic test_reset_mid_ramp();
        commit(32'd900, 32'd2000, -32'sd300, 32'd100, 1'b0);
        trig();
        checks += 2;
        if (bus.amp_h !== 32'd150) begin errors++; $display("FAIL rmr_h got %0d want 150", bus.amp_h); end
        if (bus.freq_cnt !== 32'd900) begin errors++; $display("FAIL rmr_freq got %0d want 900", bus.freq_cnt); end
        @(negedge clk);
        rst_n         = 1'b0;
        bus.step_trig = 1'b1;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.step_trig = 1'b0;
        checks += 5;
        if (bus.amp_h !== 32'd0) begin errors++; $display("FAIL rmr_rst_h got %h want 0", bus.amp_h); end
        if (bus.amp_l !== 32'd0) begin errors++; $display("FAIL rmr_rst_l got %h want 0", bus.amp_l); end
        if (bus.freq_cnt !== 32'd100) begin errors++; $display("FAIL rmr_rst_freq got %0d want 100", bus.freq_cnt); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmr_rst_busy got %b want 0", bus.busy); end
        if (bus.apply !== 1'b0) begin errors++; $display("FAIL rmr_rst_apply got %b want 0", bus.apply); end
        for (int i = 0; i < 2; i++) begin
            trig();
            checks += 4;
            if (bus.amp_h !== 32'd0) begin errors++; $display("FAIL rmr_after_h[%0d] got %h want 0", i, bus.amp_h); end
            if (bus.freq_cnt !== 32'd100) begin errors++; $display("FAIL rmr_after_freq[%0d] got %0d want 100", i, bus.freq_cnt); end
            if (bus.apply !== 1'b0) begin errors++; $display("FAIL rmr_after_apply[%0d] got %b want 0", i, bus.apply); end
            if (bus.done !== 1'b0) begin errors++; $display("FAIL rmr_after_done[%0d] got %b want 0", i, bus.done); end
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.cpu_freq_cnt = '0;
        bus.cpu_amp_h    = '0;
        bus.cpu_amp_l    = '0;
        bus.cpu_slew     = '0;
        bus.cpu_commit   = 1'b0;
        bus.step_trig    = 1'b0;
        test_reset();
        test_jump();
        test_slew();
        test_extremes();
        test_recommit();
        test_same_commit();
        test_idle_trig();
        test_commit_with_trig();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
